// File: rtl/vec_compare_sequencer.sv
// Walks a packed operand pair through a shared single-lane add/compare unit,
// one lane per cycle, and commits the sums and match flags together at the end.
module vec_compare_sequencer #(
  parameter int                LANES  = 4,
  parameter int                ELEM_W = 4,
  parameter logic [ELEM_W-1:0] TARGET = 4'hA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LANES*ELEM_W-1:0] vec_a,
  input  logic [LANES*ELEM_W-1:0] vec_b,
  output logic [ELEM_W-1:0]       cmp_a,
  output logic [ELEM_W-1:0]       cmp_b,
  input  logic [ELEM_W-1:0]       cmp_c,
  input  logic                    cmp_zero,
  output logic                    busy,
  output logic                    done,
  output logic                    result_valid,
  output logic [LANES*ELEM_W-1:0] sum_vec,
  output logic [LANES-1:0]        match_mask,
  output logic                    any_match,
  output logic                    all_match
);
  localparam int               IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [LANES*ELEM_W-1:0] r_op_a;
  logic [LANES*ELEM_W-1:0] r_op_b;
  logic [LANES*ELEM_W-1:0] r_work_sum;
  logic [LANES-1:0]        r_work_mask;
  logic [LANES*ELEM_W-1:0] r_sum;
  logic [LANES-1:0]        r_mask;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_valid;

  logic [ELEM_W-1:0]       w_lane_a [LANES];
  logic [ELEM_W-1:0]       w_lane_b [LANES];
  logic [LANES*ELEM_W-1:0] w_sum_next;
  logic [LANES-1:0]        w_mask_next;

  // Working image with the current lane replaced by this cycle's unit result,
  // so the final lane can be committed in the same edge it is produced.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_a[gi] = r_op_a[gi*ELEM_W +: ELEM_W];
      assign w_lane_b[gi] = r_op_b[gi*ELEM_W +: ELEM_W];
      assign w_sum_next[gi*ELEM_W +: ELEM_W] =
        (r_idx == IDX_W'(gi)) ? cmp_c : r_work_sum[gi*ELEM_W +: ELEM_W];
      assign w_mask_next[gi] = (r_idx == IDX_W'(gi)) ? cmp_zero : r_work_mask[gi];
    end
  endgenerate

  assign cmp_a        = r_busy ? w_lane_a[r_idx] : '0;
  assign cmp_b        = r_busy ? w_lane_b[r_idx] : '0;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_valid;
  assign sum_vec      = r_sum;
  assign match_mask   = r_mask;
  assign any_match    = |r_mask;
  assign all_match    = &r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_work_sum  <= '0;
      r_work_mask <= '0;
      r_sum       <= '0;
      r_mask      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_op_a      <= vec_a;
            r_op_b      <= vec_b;
            r_idx       <= '0;
            r_work_sum  <= '0;
            r_work_mask <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_work_sum  <= w_sum_next;
            r_work_mask <= w_mask_next;
            if (r_idx == LAST_IDX) begin
              r_sum   <= w_sum_next;
              r_mask  <= w_mask_next;
              r_valid <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
